// File: rtl/sad_min_tracker_if.sv
// rtl/sad_min_tracker_if.sv - SAD beat stream in, motion-vector result out
interface sad_min_tracker_if #(
    parameter int NUM_CAND = 16,
    parameter int SAD_W    = 16,
    parameter int MV_W     = 8
);
    logic                      sad_valid;
    logic                      sad_ready;
    logic [NUM_CAND*SAD_W-1:0] sad_results;
    logic                      block_done;
    logic                      mv_valid;
    logic                      mv_ready;
    logic [2*MV_W-1:0]         block_me;
    logic [SAD_W-1:0]          min_sad;
    logic                      row_ovf;

    modport master (
        output sad_valid, sad_results, block_done, mv_ready,
        input  sad_ready, mv_valid, block_me, min_sad, row_ovf
    );

    modport slave (
        input  sad_valid, sad_results, block_done, mv_ready,
        output sad_ready, mv_valid, block_me, min_sad, row_ovf
    );
endinterface

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - running-minimum SAD tracker returning the winning motion vector
// Optional SAD_ZERO_BIAS_EN: subtract ZERO_BIAS from the (0,0) candidate before comparing.
module sad_min_tracker #(
    parameter int NUM_CAND  = 16,
    parameter int SAD_W     = 16,
    parameter int MV_W      = 8,
    parameter int X_OFS     = 8,
    parameter int Y_OFS     = 8,
    parameter int ZERO_BIAS = 64
) (
    input  logic              clk,
    input  logic              rst,
    sad_min_tracker_if.slave  bus_io
);
    localparam int LANE_W = $clog2(NUM_CAND);
    localparam int CNT_W  = MV_W + 1;
`ifdef SAD_ZERO_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ACCUM, DRAIN1, DRAIN2, HOLD} state_t;

    state_t state_q, state_d;

    logic              beat_acc;
    logic              res_hs;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [MV_W-1:0]   row_idx;

    logic [SAD_W-1:0]  lane_sad;
    logic [SAD_W-1:0]  beat_min;
    logic [LANE_W-1:0] beat_lane;

    logic              s1_valid_q;
    logic              s1_first_q;
    logic [SAD_W-1:0]  s1_min_q;
    logic [LANE_W-1:0] s1_lane_q;
    logic [MV_W-1:0]   s1_row_q;

    logic [SAD_W-1:0]  run_min_q;
    logic [LANE_W-1:0] run_lane_q;
    logic [MV_W-1:0]   run_row_q;

    logic [MV_W-1:0]   dx_w, dy_w;
    logic [2*MV_W-1:0] block_me_q;
    logic [SAD_W-1:0]  min_sad_q;

    assign beat_acc = bus_io.sad_valid && (state_q == ACCUM);
    assign res_hs   = (state_q == HOLD) && bus_io.mv_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (beat_acc && bus_io.block_done) state_d = DRAIN1;
            DRAIN1:  state_d = DRAIN2;
            DRAIN2:  state_d = HOLD;
            HOLD:    if (bus_io.mv_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // The counter holds one extra code (2^MV_W) meaning "row space exhausted";
    // any beat arriving in that condition is the overflow.
    assign row_idx = cnt_q[MV_W] ? {MV_W{1'b1}} : cnt_q[MV_W-1:0];

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (res_hs) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (beat_acc) begin
            if (cnt_q[MV_W]) ovf_d = 1'b1;
            else             cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Strict less-than while scanning upward leaves the lowest lane on ties.
    always_comb begin
        lane_sad  = '0;
        beat_min  = '1;
        beat_lane = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            lane_sad = bus_io.sad_results[i*SAD_W +: SAD_W];
            if (BIAS_EN && (i == X_OFS) && (row_idx == MV_W'(Y_OFS)))
                lane_sad = (lane_sad > SAD_W'(ZERO_BIAS)) ? lane_sad - SAD_W'(ZERO_BIAS) : '0;
            if ((i == 0) || (lane_sad < beat_min)) begin
                beat_min  = lane_sad;
                beat_lane = LANE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_min_q   <= '0;
            s1_lane_q  <= '0;
            s1_row_q   <= '0;
        end else begin
            s1_valid_q <= beat_acc;
            if (beat_acc) begin
                s1_first_q <= (cnt_q == '0);
                s1_min_q   <= beat_min;
                s1_lane_q  <= beat_lane;
                s1_row_q   <= row_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_min_q  <= '1;
            run_lane_q <= '0;
            run_row_q  <= '0;
        end else if (res_hs) begin
            run_min_q  <= '1;
            run_lane_q <= '0;
            run_row_q  <= '0;
        end else if (s1_valid_q && (s1_first_q || (s1_min_q < run_min_q))) begin
            run_min_q  <= s1_min_q;
            run_lane_q <= s1_lane_q;
            run_row_q  <= s1_row_q;
        end
    end

    assign dx_w = MV_W'(run_lane_q) - MV_W'(X_OFS);
    assign dy_w = run_row_q - MV_W'(Y_OFS);

    // Result registers load on DRAIN2 -> HOLD and stay frozen for the whole HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_me_q <= '0;
            min_sad_q  <= '0;
        end else if (state_q == DRAIN2) begin
            block_me_q <= {dy_w, dx_w};
            min_sad_q  <= run_min_q;
        end
    end

    assign bus_io.sad_ready = (state_q == ACCUM);
    assign bus_io.mv_valid  = (state_q == HOLD);
    assign bus_io.block_me  = block_me_q;
    assign bus_io.min_sad   = min_sad_q;
    assign bus_io.row_ovf   = ovf_q;
endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - table-driven scoreboard bench for sad_min_tracker
module tb_sad_min_tracker;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sad_min_tracker_if #(.NUM_CAND(16), .SAD_W(16), .MV_W(8)) bus ();

    sad_min_tracker #(
        .NUM_CAND(16), .SAD_W(16), .MV_W(8), .X_OFS(8), .Y_OFS(8), .ZERO_BIAS(64)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        int              nbeats;
        int              base;
        int              nspec;
        logic [3:0][15:0] sr;
        logic [3:0][7:0]  sl;
        logic [3:0][15:0] sv;
        int              hold;
        logic            gaps;
        logic [15:0]     exp_me;
        logic [15:0]     exp_sad;
        logic            exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] me;
        logic [15:0] sad;
        logic        ovf;
    } exp_t;

    vec_t vecs [7];
    exp_t sbq [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mkv(input int i, input int nb, input int base, input int hold, input logic gaps,
                       input logic [15:0] me, input logic [15:0] sad, input logic ovf);
        vecs[i]         = '0;
        vecs[i].nbeats  = nb;
        vecs[i].base    = base;
        vecs[i].hold    = hold;
        vecs[i].gaps    = gaps;
        vecs[i].exp_me  = me;
        vecs[i].exp_sad = sad;
        vecs[i].exp_ovf = ovf;
    endtask

    task automatic add_sp(input int i, input int r, input int l, input int v);
        int k;
        k = vecs[i].nspec;
        vecs[i].sr[k] = 16'(r);
        vecs[i].sl[k] = 8'(l);
        vecs[i].sv[k] = 16'(v);
        vecs[i].nspec = k + 1;
    endtask

    function automatic logic [15:0] sad_of(input vec_t v, input int b, input int l);
        logic [15:0] s;
        s = v.base[15:0];
        for (int k = 0; k < v.nspec; k++)
            if ((int'(v.sr[k]) == b) && (int'(v.sl[k]) == l)) s = v.sv[k];
        return s;
    endfunction

    task automatic run_block(input vec_t v, input string tag);
        exp_t e;
        int   waitc;
        for (int b = 0; b < v.nbeats; b++) begin
            if (v.gaps && b > 0) begin
                bus.sad_valid   = 1'b0;
                bus.block_done  = 1'b1;
                bus.sad_results = '0;
                @(posedge clk); #1;
            end
            if (b == 0) check({tag, " ready_at_start"}, 32'(bus.sad_ready), 32'd1);
            for (int l = 0; l < 16; l++) bus.sad_results[l*16 +: 16] = sad_of(v, b, l);
            bus.sad_valid  = 1'b1;
            bus.block_done = (b == v.nbeats - 1);
            if (b == v.nbeats - 1) sbq.push_back({v.exp_me, v.exp_sad, v.exp_ovf});
            @(posedge clk); #1;
        end
        bus.sad_valid  = 1'b0;
        bus.block_done = 1'b0;
        check({tag, " ready_low_in_drain"}, 32'(bus.sad_ready), 32'd0);
        waitc = 0;
        while (!bus.mv_valid && waitc < 12) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, " result_latency"}, 32'(waitc), 32'd2);
        if (bus.mv_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, " block_me"}, 32'(bus.block_me), 32'(e.me));
            check({tag, " min_sad"},  32'(bus.min_sad),  32'(e.sad));
            check({tag, " row_ovf"},  32'(bus.row_ovf),  32'(e.ovf));
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk); #1;
                check({tag, " hold_valid"}, 32'(bus.mv_valid),  32'd1);
                check({tag, " hold_me"},    32'(bus.block_me),  32'(e.me));
                check({tag, " hold_ready"}, 32'(bus.sad_ready), 32'd0);
            end
        end
        bus.mv_ready = 1'b1;
        @(posedge clk); #1;
        bus.mv_ready = 1'b0;
        check({tag, " valid_after_hs"}, 32'(bus.mv_valid),  32'd0);
        check({tag, " ready_after_hs"}, 32'(bus.sad_ready), 32'd1);
        check({tag, " ovf_after_hs"},   32'(bus.row_ovf),   32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sad_ready"}, 32'(bus.sad_ready), 32'd1);
        check({tag, " mv_valid"},  32'(bus.mv_valid),  32'd0);
        check({tag, " block_me"},  32'(bus.block_me),  32'd0);
        check({tag, " min_sad"},   32'(bus.min_sad),   32'd0);
        check({tag, " row_ovf"},   32'(bus.row_ovf),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        mkv(0, 16, 500, 10, 1'b0, 16'hFB04, 16'd100, 1'b0);
        add_sp(0, 3, 12, 100);
        mkv(1, 16, 1000, 0, 1'b1, 16'hFAFD, 16'd50, 1'b0);
        add_sp(1, 2, 5, 50); add_sp(1, 2, 7, 50); add_sp(1, 9, 5, 50); add_sp(1, 9, 7, 50);
        mkv(2, 1, 300, 0, 1'b0, 16'hF8F8, 16'd0, 1'b0);
        add_sp(2, 0, 0, 0);
        mkv(3, 257, 200, 2, 1'b0, 16'h2007, 16'd10, 1'b1);
        add_sp(3, 40, 15, 10);
`ifdef SAD_ZERO_BIAS_EN
        mkv(4, 16, 500, 0, 1'b0, 16'h0000, 16'd56, 1'b0);
`else
        mkv(4, 16, 500, 0, 1'b0, 16'hF8F8, 16'd100, 1'b0);
`endif
        add_sp(4, 8, 8, 120); add_sp(4, 0, 0, 100);
        mkv(5, 16, 65535, 0, 1'b0, 16'h0707, 16'd7, 1'b0);
        add_sp(5, 15, 15, 7);
        mkv(6, 256, 200, 0, 1'b0, 16'hF7F8, 16'd1, 1'b0);
        add_sp(6, 255, 0, 1);

        rst             = 1'b1;
        bus.sad_valid   = 1'b0;
        bus.block_done  = 1'b0;
        bus.sad_results = '0;
        bus.mv_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        bus.mv_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_mv_ready valid", 32'(bus.mv_valid),  32'd0);
        check("idle_mv_ready ready", 32'(bus.sad_ready), 32'd1);
        bus.mv_ready = 1'b0;

        for (int i = 0; i < 7; i++) run_block(vecs[i], $sformatf("vec%0d", i));

        for (int b = 0; b < 5; b++) begin
            for (int l = 0; l < 16; l++) bus.sad_results[l*16 +: 16] = 16'd1;
            bus.sad_valid  = 1'b1;
            bus.block_done = 1'b0;
            @(posedge clk); #1;
        end
        bus.sad_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_outputs("midblock_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_block(vecs[0], "after_reset");

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
